// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and types for the MEM/WB pipeline register.
package mem_wb_pipe_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  // Occupancy of the two-deep skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Width of one packed MEM->WB entry: per-lane {wd, wreg, wdata} plus {whilo, hi, lo}.
  function automatic int entry_width(input int lanes, input int addr_w, input int data_w);
    return lanes * (addr_w + 1 + data_w) + 1 + 2 * data_w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// Generic two-entry skid buffer: main register drives the output, skid register
// absorbs one extra entry so in_ready can be a pure register.
module skid_buf
  import mem_wb_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, pop;

  assign accept      = in_valid_i && in_ready_q;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;

  // Next-state and storage-load decisions; flush wins over any transfer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_HALF;
          main_d  = in_data_i;
        end
      end
      ST_HALF: begin
        if (accept && pop) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data_i;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    // Registered ready: depends only on the next occupancy, never on out_ready_i directly.
    in_ready_d = (state_d != ST_FULL);
  end

  // State, storage and ready registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst == RstEnable) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: the data registers are cleared too, so no stale payload survives a reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with backpressure, $0-write suppression and a retire counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ADDR_W-1:0]  mem_wd,
  input  logic [LANES-1:0]         mem_wreg,
  input  logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ADDR_W-1:0]  wb_wd,
  output logic [LANES-1:0]         wb_wreg,
  output logic [LANES*DATA_W-1:0]  wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [CNT_W-1:0]         retire_cnt
);

  localparam int EW = entry_width(LANES, ADDR_W, DATA_W);

  logic [LANES-1:0]        wreg_eff;
  logic [EW-1:0]           in_entry, out_entry;
  logic [LANES*ADDR_W-1:0] ent_wd;
  logic [LANES-1:0]        ent_wreg;
  logic [LANES*DATA_W-1:0] ent_wdata;
  logic                    ent_whilo;
  logic [DATA_W-1:0]       ent_hi, ent_lo;
  logic [CNT_W-1:0]        retire_q, retire_d;
  logic                    pop;

  // A write to register $0 is architecturally a no-op, so drop its enable on entry.
  always_comb begin
    wreg_eff = '0;
    for (int i = 0; i < LANES; i++) begin
      wreg_eff[i] = mem_wreg[i] && (mem_wd[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  assign in_entry = {mem_wd, wreg_eff, mem_wdata, mem_whilo, mem_hi, mem_lo};

  skid_buf #(
    .W (EW)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_entry)
  );

  assign {ent_wd, ent_wreg, ent_wdata, ent_whilo, ent_hi, ent_lo} = out_entry;

  // Present the held entry only while valid; otherwise drive an inert NOP payload.
  always_comb begin
    wb_wd    = {LANES{ADDR_W'(NOPRegAddr)}};
    wb_wreg  = {LANES{WriteDisable}};
    wb_wdata = {LANES{DATA_W'(ZeroWord)}};
    wb_whilo = WriteDisable;
    wb_hi    = DATA_W'(ZeroWord);
    wb_lo    = DATA_W'(ZeroWord);
    if (out_valid) begin
      wb_wd    = ent_wd;
      wb_wreg  = ent_wreg;
      wb_wdata = ent_wdata;
      wb_whilo = ent_whilo;
      wb_hi    = ent_hi;
      wb_lo    = ent_lo;
    end
  end

  assign pop        = out_valid && out_ready;
  assign retire_d   = retire_q + CNT_W'(1);
  assign retire_cnt = retire_q;

  // Retire counter: counts every consumed entry, flush-cycle pops included; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      retire_q <= '0;
    end else if (pop) begin
      retire_q <= retire_d;
    end
  end

endmodule
